// File: rtl/write_buffer_controller.sv
// Drains NUM_WORDS scratchpad words into an output buffer, one word per read/latch/write round.
// States: IDLE wait job | RD_SCR read strobe | LATCH capture data | WR_REQ offer word | DONE pulse done
module write_buffer_controller #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int NUM_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inner_rst,
  input  logic              start,
  input  logic              result_ready,
  output logic              read_req_scratch,
  output logic [ADDR_W-1:0] scratch_raddr,
  input  logic [DATA_W-1:0] scratch_rdata,
  input  logic              buf_full,
  output logic              write_req_buffer,
  output logic [DATA_W-1:0] buf_wdata,
  input  logic              buf_ack,
  output logic              cnt,
  output logic              done,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_SCR = 3'd1,
    LATCH  = 3'd2,
    WR_REQ = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                xfer;

  always_ff @(posedge clk) begin
    if (rst || inner_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    data_d           = data_q;
    read_req_scratch = 1'b0;
    write_req_buffer = 1'b0;
    cnt              = 1'b0;
    done             = 1'b0;
    busy             = 1'b1;
    xfer             = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start && result_ready) state_d = RD_SCR;
      end
      RD_SCR: begin
        read_req_scratch = 1'b1;
        state_d          = LATCH;
      end
      LATCH: begin
        data_d  = scratch_rdata;
        state_d = WR_REQ;
      end
      WR_REQ: begin
        // an ack only counts while the request is actually offered
        write_req_buffer = ~buf_full;
        xfer             = ~buf_full & buf_ack;
        cnt              = xfer;
        if (xfer) begin
          if (addr_q == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = RD_SCR;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        addr_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign scratch_raddr = addr_q;
  assign buf_wdata     = data_q;

endmodule
